// File: rtl/crab_pkg.sv
// Shared definitions for the crab multi-cycle RV32I core: FSM states,
// major opcodes and trap cause codes.
package crab_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    WB    = 3'd3,
    TRAP  = 3'd4
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  localparam logic [3:0] CAUSE_TGT_MISALIGN   = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL          = 4'd11;

endpackage

// File: rtl/crab_regfile.sv
// Architectural register file: two async read ports, one sync write port,
// x0 hardwired to zero.
module crab_regfile
  import crab_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);

  localparam int AW = $clog2(NUM_REGS);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (rd_addr != 5'd0)) begin
      regs[rd_addr[AW-1:0]] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr[AW-1:0]];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr[AW-1:0]];

endmodule

// File: rtl/crabcore_p.sv
// Multi-cycle RV32I/RV32E core: FETCH -> EXEC -> (MEM) -> WB, with a
// one-cycle TRAP state redirecting to TRAP_PC.
module crabcore_p
  import crab_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        trap,
  output logic [3:0]  trap_cause,
  output logic [31:0] pc_debug,
  output logic [2:0]  state_debug
);

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic signed [31:0] a,
                                      input logic signed [31:0] b);
    case (f3)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'd0, (a < b)};
      3'b011:  return {31'd0, ($unsigned(a) < $unsigned(b))};
      3'b100:  return a ^ b;
      3'b101:  return alt ? a >>> b[4:0] : $unsigned(a) >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_cond(input logic [2:0] f3,
                                   input logic signed [31:0] a,
                                   input logic signed [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return a < b;
      3'b101:  return a >= b;
      3'b110:  return $unsigned(a) < $unsigned(b);
      default: return $unsigned(a) >= $unsigned(b);
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lo, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] v);
    case (f3[1:0])
      2'b00:   return {24'd0, v[7:0]} << {lo, 3'b000};
      2'b01:   return {16'd0, v[15:0]} << {lo, 3'b000};
      default: return v;
    endcase
  endfunction

  localparam logic RV32E = (NUM_REGS == 16);

  state_e      state;
  logic [31:0] pc;
  logic [31:0] instr_p0;
  logic [31:0] res_p1, npc_p1;
  logic [1:0]  ea_lo_p1;
  logic        rd_we_p1;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, ea;

  logic [31:0] ex_res, ex_npc;
  logic [3:0]  ex_cause;
  logic ex_we, ex_taken, ex_load, ex_store, ex_illegal, ex_ecall, ex_ebreak;
  logic use_rs1, use_rs2, ld_mis, st_mis, tgt_mis, ex_trap;

  assign opcode = instr_p0[6:0];
  assign rd     = instr_p0[11:7];
  assign f3     = instr_p0[14:12];
  assign rs1    = instr_p0[19:15];
  assign rs2    = instr_p0[24:20];
  assign f7     = instr_p0[31:25];
  assign imm_i  = {{20{instr_p0[31]}}, instr_p0[31:20]};
  assign imm_s  = {{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
  assign imm_b  = {{19{instr_p0[31]}}, instr_p0[31], instr_p0[7], instr_p0[30:25],
                   instr_p0[11:8], 1'b0};
  assign imm_u  = {instr_p0[31:12], 12'd0};
  assign imm_j  = {{11{instr_p0[31]}}, instr_p0[31], instr_p0[19:12], instr_p0[20],
                   instr_p0[30:21], 1'b0};

  crab_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .we       ((state == WB) && rd_we_p1),
    .rd_addr  (rd),
    .rd_data  (res_p1)
  );

  // EXEC stage: decode, ALU, branch resolution and address generation
  always_comb begin
    ex_res = '0; ex_npc = pc + 32'd4; ex_we = 1'b0; ex_taken = 1'b0;
    ex_load = 1'b0; ex_store = 1'b0; ex_illegal = 1'b0;
    ex_ecall = 1'b0; ex_ebreak = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    case (opcode)
      OP_LUI:   begin ex_res = imm_u; ex_we = 1'b1; end
      OP_AUIPC: begin ex_res = pc + imm_u; ex_we = 1'b1; end
      OP_JAL:   begin ex_res = pc + 32'd4; ex_we = 1'b1; ex_taken = 1'b1; ex_npc = pc + imm_j; end
      OP_JALR: begin
        use_rs1 = 1'b1; ex_res = pc + 32'd4; ex_we = 1'b1; ex_taken = 1'b1;
        ex_npc = (rs1_val + imm_i) & ~32'd1;
        ex_illegal = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        ex_illegal = (f3 == 3'b010) || (f3 == 3'b011);
        ex_taken = br_cond(f3, rs1_val, rs2_val);
        if (ex_taken) ex_npc = pc + imm_b;
      end
      OP_LOAD: begin
        use_rs1 = 1'b1; ex_we = 1'b1; ex_load = 1'b1;
        ex_illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; ex_store = 1'b1;
        ex_illegal = (f3[2] || (f3[1:0] == 2'b11));
      end
      OP_IMM: begin
        use_rs1 = 1'b1; ex_we = 1'b1;
        ex_illegal = ((f3 == 3'b001) && (f7 != 7'd0)) ||
                     ((f3 == 3'b101) && (f7 != 7'd0) && (f7 != 7'b0100000));
        ex_res = alu(f3, (f3 == 3'b101) && f7[5], rs1_val, imm_i);
      end
      OP_REG: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; ex_we = 1'b1;
        ex_illegal = (f7 != 7'd0) &&
                     !((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        ex_res = alu(f3, f7[5], rs1_val, rs2_val);
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
        ex_ecall   = (instr_p0 == INSN_ECALL);
        ex_ebreak  = (instr_p0 == INSN_EBREAK);
        ex_illegal = !ex_ecall && !ex_ebreak;
      end
      default: ex_illegal = 1'b1;
    endcase
    if (RV32E && ((ex_we && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])))
      ex_illegal = 1'b1;
  end

  assign ea      = rs1_val + (ex_store ? imm_s : imm_i);
  assign ld_mis  = ex_load  && ((f3[1:0] == 2'b01) ? ea[0] : (f3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
  assign st_mis  = ex_store && ((f3[1:0] == 2'b01) ? ea[0] : (f3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
  assign tgt_mis = ex_taken && (ex_npc[1:0] != 2'b00);
  assign ex_trap = ex_illegal || ex_ecall || ex_ebreak || ld_mis || st_mis || tgt_mis;

  always_comb begin
    if (ex_illegal)     ex_cause = CAUSE_ILLEGAL;
    else if (ex_ebreak) ex_cause = CAUSE_BREAKPOINT;
    else if (ex_ecall)  ex_cause = CAUSE_ECALL;
    else if (ld_mis)    ex_cause = CAUSE_LOAD_MISALIGN;
    else if (st_mis)    ex_cause = CAUSE_STORE_MISALIGN;
    else                ex_cause = CAUSE_TGT_MISALIGN;
  end

  // Control: FSM and bus outputs; reset abandons any outstanding transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH; pc <= RESET_PC; rd_we_p1 <= 1'b0;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_wstrb <= '0; mem_addr <= '0; mem_wdata <= '0;
      trap <= 1'b0; trap_cause <= '0;
    end else begin
      trap <= 1'b0;
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req <= 1'b1; mem_addr <= pc;
          end else if (mem_ready) begin
            mem_req <= 1'b0; state <= EXEC;
          end
        end
        EXEC: begin
          rd_we_p1 <= ex_we && !ex_trap;
          if (ex_trap) begin
            state <= TRAP; trap <= 1'b1; trap_cause <= ex_cause;
          end else if (ex_load || ex_store) begin
            state     <= MEM;
            mem_req   <= 1'b1;
            mem_we    <= ex_store;
            mem_addr  <= {ea[31:2], 2'b00};
            mem_wstrb <= ex_store ? st_strb(f3, ea[1:0]) : 4'b0000;
            mem_wdata <= ex_store ? st_data(f3, ea[1:0], rs2_val) : 32'd0;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0; mem_we <= 1'b0; mem_wstrb <= '0; state <= WB;
          end
        end
        WB: begin
          pc <= npc_p1; mem_req <= 1'b1; mem_addr <= npc_p1; state <= FETCH;
        end
        TRAP: begin
          pc <= TRAP_PC; mem_req <= 1'b1; mem_addr <= TRAP_PC; state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Datapath registers carried between states
  always_ff @(posedge clk) begin
    if ((state == FETCH) && mem_req && mem_ready) instr_p0 <= mem_rdata;
    if (state == EXEC) begin
      res_p1   <= ex_res;
      npc_p1   <= ex_npc;
      ea_lo_p1 <= ea[1:0];
    end
    if ((state == MEM) && mem_ready && (opcode == OP_LOAD))
      res_p1 <= load_ext(f3, ea_lo_p1, mem_rdata);
  end

  assign pc_debug    = pc;
  assign state_debug = state;

endmodule

// File: doc/crabcore_p.md
CRABCORE_P -- requirements
Module: crabcore_p

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TRAP_PC, default 32'h0000_0100, meaning the PC loaded on any trap.
REQ-003 SHALL have parameter NUM_REGS, default 32, meaning the architectural register count; legal values are 32 (RV32I) and 16 (RV32E).
REQ-004 SHALL have port clk, input, 1, system clock; all state updates on posedge clk only.
REQ-005 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have ports mem_req out 1 (request), mem_we out 1 (write), mem_addr out 32 (word address), mem_wdata out 32 (lane-aligned store data) and mem_wstrb out 4 (byte enables).
REQ-007 SHALL have ports mem_ready in 1 (transfer completes this cycle) and mem_rdata in 32 (read data, valid when mem_ready=1).
REQ-008 SHALL have ports trap out 1 (one-cycle pulse), trap_cause out 4 (code for the last trap), pc_debug out 32 (current PC) and state_debug out 3 (current FSM state).

Function
REQ-009 SHALL implement the RV32I base ISA, excluding CSR access; FENCE/FENCE.I SHALL execute as no-ops.
REQ-010 SHALL use the FSM states FETCH, EXEC, MEM, WB and TRAP; FETCH SHALL be the only state that starts an instruction.
REQ-011 In FETCH, the core SHALL assert mem_req=1, mem_we=0 and mem_addr=pc, and SHALL hold them until mem_ready=1; it SHALL latch mem_rdata as the instruction and go to EXEC.
REQ-012 EXEC SHALL take one cycle: decode, read rs1/rs2, compute the ALU result, branch decision and effective address; it SHALL go to MEM for load/store, TRAP on an exception, otherwise WB.
REQ-013 In MEM, the core SHALL drive mem_req=1, mem_addr={ea[31:2],2'b00}, mem_we and mem_wstrb/mem_wdata shifted by ea[1:0], and SHALL hold them stable until mem_ready=1, then go to WB.
REQ-014 For loads, the core SHALL extract the byte, half or word from mem_rdata using ea[1:0], then sign- or zero-extend it per funct3.
REQ-015 WB SHALL write rd when the instruction writes a register, update the PC (pc+4, branch/JAL/JALR target with JALR bit0 cleared), and return to FETCH.
REQ-016 Latency at zero wait states (mem_ready tied 1) SHALL be 3 cycles for ALU/branch/jump/LUI/AUIPC and 4 cycles for loads/stores.
REQ-017 Writes to x0 SHALL be discarded, and x0 SHALL always read as 0.
REQ-018 Traps SHALL be raised from EXEC with trap_cause 2 for an illegal opcode/funct, 3 for EBREAK, 11 for ECALL, 4 for a misaligned load and 6 for a misaligned store.
REQ-019 With NUM_REGS=16, any rd/rs1/rs2 with bit4=1 SHALL be illegal (cause 2).
REQ-020 A branch or jump target with target[1:0]!=0 SHALL trap with cause 0 when taken, and the PC SHALL not be updated.
REQ-021 On a misaligned access, the core SHALL not issue mem_req.
REQ-022 The TRAP state SHALL last one cycle: trap=1, trap_cause updated, pc<=TRAP_PC, rd not written, next state FETCH.
REQ-023 mem_req SHALL be 0 in EXEC, WB and TRAP.
REQ-024 mem_addr, mem_we, mem_wdata and mem_wstrb SHALL not change while mem_req=1 and mem_ready=0.
REQ-025 mem_ready SHALL be ignored when mem_req=0.

Reset
REQ-026 On reset, the core SHALL set state=FETCH, pc=RESET_PC, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, trap=0, trap_cause=0, and clear all registers to 0.
REQ-027 Reset SHALL take priority over every state, including a pending MEM transfer; the outstanding transfer SHALL be abandoned without a write.
REQ-028 The first mem_req=1 SHALL occur in the cycle after reset deasserts, with mem_addr=RESET_PC.

Structure
REQ-029 Opcode localparams, trap cause codes and the state enum SHALL live in a shared package crab_pkg.
REQ-030 The register file SHALL be a sub-module crab_regfile, parametrised by NUM_REGS, with 2 async read ports, 1 sync write port and hardwired x0.
REQ-031 All other logic (FSM, decode, ALU, load/store alignment) SHALL reside in crabcore_p.

Verification
REQ-032 Bench SHALL cover: ADDI x1,x0,5; ADDI x2,x1,-7 with mem_ready=1 -> x2=32'hFFFF_FFFE, 3 cycles per instruction.
REQ-033 Bench SHALL cover: SB x2,3(x0) with x2=0xAB -> mem_wstrb=4'b1000, mem_wdata=32'hAB00_0000, mem_addr=0; then LB x3,3(x0) -> x3=32'hFFFF_FFAB.
REQ-034 Bench SHALL cover: LW x4,2(x0) -> no mem_req in MEM, trap pulse, trap_cause=4, pc=TRAP_PC, x4 unchanged.
REQ-035 Bench SHALL cover: NUM_REGS=16 build, ADD x17,x1,x2 -> trap_cause=2; ECALL -> trap_cause=11.
REQ-036 Bench SHALL cover: FETCH with mem_ready held 0 for 5 cycles -> mem_addr/mem_req stable, state_debug=FETCH; reset asserted in MEM of SW -> no write completes, pc=RESET_PC.
REQ-037 Bench SHALL cover: BEQ x0,x0,-4 at pc=8 -> pc=4; JALR x1,0(x5) with x5=0x21 -> pc=0x20, x1=pc+4.
